// File: rtl/serial_pkg.sv
// Shared types and constants for the serializer front end and the 1011 detector path.
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [3:0] DETECT_PATTERN = 4'b1011;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Word-load handshake plus serial-side outputs of the bit-stream serializer.
interface bit_stream_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             last_bit;
  logic             busy;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready,
    input  out,
    input  out_valid,
    input  last_bit,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready,
    output out,
    output out_valid,
    output last_bit,
    output busy
  );
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter: accepts WIDTH-bit words and emits one bit per clock,
// holding the line at IDLE_BIT between words so the downstream detector sees clean fill.
module bit_stream_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  bit_stream_serializer_if.slave  ser_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             last_q, last_d;
  logic             load_ready;
  logic             accept;

  // Ready in IDLE or while the final bit of the current word is on the line.
  assign load_ready = !reset && ((state_q == IDLE) || (cnt_q == '0));
  assign accept     = ser_io.load_valid && load_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    out_d       = IDLE_BIT;
    out_valid_d = 1'b0;
    last_d      = 1'b0;

    if (accept) begin
      // First bit goes straight to the output register; the remainder shifts from sreg.
      state_d     = SHIFT;
      cnt_d       = CntW'(WIDTH - 1);
      out_d       = MSB_FIRST ? ser_io.data_in[WIDTH-1] : ser_io.data_in[0];
      sreg_d      = MSB_FIRST ? (ser_io.data_in << 1) : (ser_io.data_in >> 1);
      out_valid_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            cnt_d       = cnt_q - 1'b1;
            out_d       = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
            sreg_d      = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            out_valid_d = 1'b1;
            last_d      = (cnt_q == CntW'(1));
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign ser_io.load_ready = load_ready;
  assign ser_io.out        = out_q;
  assign ser_io.out_valid  = out_valid_q;
  assign ser_io.last_bit   = last_q;
  assign ser_io.busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: MSB-first and LSB-first instances, reset
// behaviour, back-to-back streaming and a reference 1011 detector on the serial line.
module tb_bit_stream_serializer;
  import serial_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bit_stream_serializer_if #(.WIDTH(8)) a_if ();
  bit_stream_serializer_if #(.WIDTH(8)) b_if ();

  bit_stream_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1),
    .IDLE_BIT (1'b0)
  ) u_msb (
    .clk   (clk),
    .reset (reset),
    .ser_io(a_if)
  );

  bit_stream_serializer #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0),
    .IDLE_BIT (1'b0)
  ) u_lsb (
    .clk   (clk),
    .reset (reset),
    .ser_io(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-line checks on instance A.
  task automatic chk_idle_a(input string tag);
    chk({tag, "_out"}, a_if.out, 1'b0);
    chk({tag, "_valid"}, a_if.out_valid, 1'b0);
    chk({tag, "_last"}, a_if.last_bit, 1'b0);
    chk({tag, "_busy"}, a_if.busy, 1'b0);
  endtask

  initial begin
    logic [7:0]  word;
    logic [15:0] pair;
    logic [3:0]  hist;
    total = 0;
    bad   = 0;

    // Reset held two cycles with load_valid high: nothing accepted.
    reset         = 1'b1;
    a_if.load_valid = 1'b1;
    a_if.data_in    = 8'hAA;
    b_if.load_valid = 1'b0;
    b_if.data_in    = 8'h00;
    tick();
    chk_idle_a("rst1");
    chk("rst1_ready", a_if.load_ready, 1'b0);
    tick();
    chk_idle_a("rst2");
    chk("rst2_ready", a_if.load_ready, 1'b0);
    reset           = 1'b0;
    a_if.load_valid = 1'b0;
    #1;
    chk("rel_ready", a_if.load_ready, 1'b1);
    tick();
    chk_idle_a("rel");
    chk("rel_ready2", a_if.load_ready, 1'b1);

    // Single word MSB-first.
    word            = 8'b1011_0010;
    a_if.data_in    = word;
    a_if.load_valid = 1'b1;
    tick();
    a_if.load_valid = 1'b0;
    a_if.data_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("msb_out%0d", i), a_if.out, word[7-i]);
      chk($sformatf("msb_valid%0d", i), a_if.out_valid, 1'b1);
      chk($sformatf("msb_last%0d", i), a_if.last_bit, (i == 7));
      chk($sformatf("msb_ready%0d", i), a_if.load_ready, (i == 7));
      chk($sformatf("msb_busy%0d", i), a_if.busy, 1'b1);
      tick();
    end
    chk_idle_a("msb_after");
    chk("msb_after_ready", a_if.load_ready, 1'b1);

    // Back-to-back words with load_valid held through the last-bit cycle.
    pair            = {8'hB0, 8'h0B};
    a_if.data_in    = 8'hB0;
    a_if.load_valid = 1'b1;
    tick();
    a_if.data_in    = 8'h0B;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_out%0d", i), a_if.out, pair[15-i]);
      chk($sformatf("b2b_valid%0d", i), a_if.out_valid, 1'b1);
      chk($sformatf("b2b_last%0d", i), a_if.last_bit, (i == 7) || (i == 15));
      chk($sformatf("b2b_ready%0d", i), a_if.load_ready, (i == 7) || (i == 15));
      tick();
      if (i == 7) a_if.load_valid = 1'b0;
    end
    chk_idle_a("b2b_after");

    // Reset asserted during bit 3 of a word; partial word discarded.
    a_if.data_in    = 8'b1011_0010;
    a_if.load_valid = 1'b1;
    tick();
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_bit3", a_if.out, 1'b1);
    reset = 1'b1;
    tick();
    chk_idle_a("mid_rst");
    chk("mid_rst_ready", a_if.load_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_rel_ready", a_if.load_ready, 1'b1);
    a_if.data_in    = 8'hFF;
    a_if.load_valid = 1'b1;
    tick();
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ff_out%0d", i), a_if.out, 1'b1);
      chk($sformatf("ff_last%0d", i), a_if.last_bit, (i == 7));
      tick();
    end
    chk_idle_a("ff_after");

    // Serial line into a 1011 detector; idle fill must never trigger it.
    hist            = 4'b0000;
    word            = 8'b1011_1011;
    a_if.data_in    = word;
    a_if.load_valid = 1'b1;
    tick();
    a_if.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("det_out%0d", i), a_if.out, word[7-i]);
      hist = {hist[2:0], a_if.out};
      chk($sformatf("det_hit%0d", i), (hist == DETECT_PATTERN), (i == 3) || (i == 7));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      hist = {hist[2:0], a_if.out};
      chk($sformatf("det_idle%0d", i), (hist == DETECT_PATTERN), 1'b0);
      tick();
    end

    // LSB-first instance.
    chk("lsb_pre_out", b_if.out, 1'b0);
    chk("lsb_pre_valid", b_if.out_valid, 1'b0);
    word            = 8'b0000_1101;
    b_if.data_in    = word;
    b_if.load_valid = 1'b1;
    tick();
    b_if.load_valid = 1'b0;
    b_if.data_in    = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_out%0d", i), b_if.out, word[i]);
      chk($sformatf("lsb_valid%0d", i), b_if.out_valid, 1'b1);
      chk($sformatf("lsb_last%0d", i), b_if.last_bit, (i == 7));
      tick();
    end
    chk("lsb_after_out", b_if.out, 1'b0);
    chk("lsb_after_valid", b_if.out_valid, 1'b0);
    chk("lsb_after_busy", b_if.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line that drives the `in` port of `seq_detector_1011`. Back-to-back words stream with no idle gap. Between words the line is held at a fixed idle level, so the downstream detector, which has no enable, sees only deterministic bits.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_BIT, 0: level driven on `out` whenever no word is shifting.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- data_in  input  WIDTH  word to serialize; sampled only on the accept edge.
- load_valid  input  1  upstream has a word on data_in.
- load_ready  output  1  combinational; block can accept a word this cycle.
- out  output  1  registered serial bit, connects to detector `in`.
- out_valid  output  1  registered; `out` carries a word bit this cycle.
- last_bit  output  1  registered; high with the final bit of each word.
- busy  output  1  registered; high while in SHIFT.

## Operation
- States:
  - IDLE: out=IDLE_BIT, out_valid=0, load_ready=1.
  - SHIFT: one word bit on `out` per cycle.
- Accept: a word is accepted on a rising edge where load_valid && load_ready. On that edge the shift register takes data_in and the state goes to SHIFT. The bit counter loads WIDTH-1.
- SHIFT, each edge: drive the next bit and decrement the counter.
  - MSB_FIRST=1: shift left; the bit is taken from the top.
  - MSB_FIRST=0: shift right; the bit is taken from the bottom.
- load_ready is high in IDLE, or in SHIFT when the counter is 0 (last bit on the line). Otherwise it is 0.
- At counter 0:
  - With an accept: reload and stay in SHIFT. The first bit of the new word follows the last bit of the old word with zero gap.
  - Without an accept: go to IDLE. The next cycle shows out=IDLE_BIT and out_valid=0.
- last_bit is high exactly when out_valid=1 and the bit shown is the word's final bit.
- Counter width: $clog2(WIDTH). It never wraps below 0, and no decrement is applied at 0.
- data_in changes outside the accept edge are ignored. The captured word is immutable during shifting.

## Timing
- Latency: accept on edge k. Bit 0 of the stream is on `out` in the cycle after edge k. The word occupies exactly WIDTH consecutive cycles.
- Throughput: one bit per cycle sustained; one word per WIDTH cycles when load_valid is held high.
- Values while reset is high, and after the first edge with reset high:
  - out=IDLE_BIT
  - out_valid=0
  - last_bit=0
  - busy=0
  - load_ready=0
  - state=IDLE
  - counter=0
  - shift register=0
- Reset mid-word: the partially sent word is discarded with no resume. On the first edge after reset deasserts, load_ready=1.
- Reset and load_valid in the same cycle: reset wins and the word is not accepted.
- load_valid held while load_ready=0: the word waits for the last-bit cycle. Upstream must hold data_in stable until accepted.

## Structure
- Shared package `serial_pkg`:
  - state enum {IDLE, SHIFT}.
  - DEFAULT_WIDTH=8.
  - DETECT_PATTERN=4'b1011, shared with the detector bench.
- Single module; no sub-module. The counter and shift register are small enough to stay inline.

## Test plan
- Reset: hold reset 2 cycles with load_valid=1 -> out=0, out_valid=0, load_ready=0, no accept. load_ready=1 on the edge after deassertion.
- Single word, MSB_FIRST=1, data_in=8'b1011_0010 -> out sequence 1,0,1,1,0,0,1,0 with out_valid=1 for 8 cycles. last_bit only on the 8th cycle. Then out=IDLE_BIT and out_valid=0.
- Back-to-back: 8'hB0 then 8'h0B, load_valid held -> 16 contiguous valid cycles. The second accept occurs on the 8th bit cycle. load_ready=0 during bits 1..7.
- LSB-first: MSB_FIRST=0, data_in=8'b0000_1101 -> out sequence 1,0,1,1,0,0,0,0.
- Reset mid-word: assert reset during bit 3 -> out_valid=0 and out=IDLE_BIT on the next cycle. A following word 8'hFF streams 8 ones correctly.
- Chained with seq_detector_1011: stream 8'b1011_1011 -> detected pulses after the 4th and 8th bits. No detection occurs during idle fill.
